key_select: RTL and testbench

Parametrised, debounced front end for the board push-buttons. Synchronises and debounces `NUM_KEYS` raw key inputs, detects press edges, rejects multi-key presses, and presents each accepted single-key selection, as one-hot and as an index, to the game controller over a one-entry valid/ready handshake. Also provides a level `any_pressed` flag.

---
 rtl/key_select.sv | 147 ++++++++++++++
 tb/tb_key_select.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_select.sv
// key_select: debounced push-button front end. Each key is synchronised and
// debounced in its own lane; press edges on exactly one key become selections
// held in a one-entry valid/ready register, and multi-key presses are rejected.

// Per-key lane: polarity fix, two-flop synchroniser, stable-state debouncer.
module key_select_lane #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic db
);
  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          p;

  assign p = KEY_ACTIVE_LOW ? ~key : key;

  // Two-flop synchroniser. It resets to "not pressed", so a key held across
  // reset is seen as a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= p;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has disagreed with db for
  // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      db  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

module key_select #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] sel_onehot,
  output logic [IW-1:0]       sel_index,
  output logic                sel_valid,
  input  logic                sel_ready,
  output logic                any_pressed,
  output logic                multi_press,
  output logic                dropped
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state;
  logic [NUM_KEYS-1:0] db, db_prev, rise;
  logic                any_rise, single, ev;
  logic [IW-1:0]       ev_idx;

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_lane
      key_select_lane #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .key   (key[g]),
        .db    (db[g])
      );
    end
  endgenerate

  // Previous debounced state for press-edge detection.
  always_ff @(posedge clk) begin
    if (reset) db_prev <= '0;
    else       db_prev <= db;
  end

  assign rise        = db & ~db_prev;
  assign any_rise    = |rise;
  // Exactly one key down: non-zero with a single bit set.
  assign single      = (db != '0) && ((db & (db - NUM_KEYS'(1))) == '0);
  assign ev          = any_rise & single;
  assign any_pressed = |db;
  assign sel_valid   = (state == FULL);

  // Index of the single pressed key (only meaningful when ev is high).
  always_comb begin
    ev_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (db[i]) ev_idx = IW'(i);
  end

  // Holding register: EMPTY/FULL with back-to-back reload on a same-cycle
  // consume, and one-cycle pulses for rejected or lost presses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      sel_onehot  <= '0;
      sel_index   <= '0;
      multi_press <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      multi_press <= any_rise & ~single;
      dropped     <= 1'b0;
      case (state)
        EMPTY: begin
          if (ev) begin
            state      <= FULL;
            sel_onehot <= db;
            sel_index  <= ev_idx;
          end
        end
        FULL: begin
          if (sel_ready) begin
            if (ev) begin
              sel_onehot <= db;
              sel_index  <= ev_idx;
            end else begin
              state <= EMPTY;
            end
          end else if (ev) begin
            dropped <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_key_select.sv
// Bench for key_select: directed scenarios with literal expectations plus a
// randomised phase, all checked every cycle against a behavioural model.
module tb_key_select;
  localparam int NK  = 4;
  localparam int D   = 4;
  localparam bit KAL = 1'b1;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key;
  logic [NK-1:0] sel_onehot;
  logic [IW-1:0] sel_index;
  logic          sel_valid, sel_ready, any_pressed, multi_press, dropped;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  key_select #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(KAL)) dut (
    .clk         (clk),
    .reset       (reset),
    .key         (key),
    .sel_onehot  (sel_onehot),
    .sel_index   (sel_index),
    .sel_valid   (sel_valid),
    .sel_ready   (sel_ready),
    .any_pressed (any_pressed),
    .multi_press (multi_press),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A key's debounced level flips once its last D synchronised samples all
  // disagree with the current level.
  logic [NK-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_dbp = '0, m_oh = '0;
  logic [IW-1:0] m_idx = '0;
  bit            m_full = 0, m_mp = 0, m_dr = 0;
  bit            hist[NK][$];
  logic [NK-1:0] m_rise;
  bit            m_ev, all_diff;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0; m_oh = '0; m_idx = '0;
      m_full = 0; m_mp = 0; m_dr = 0;
      for (int k = 0; k < NK; k++) hist[k].delete();
    end else begin
      m_rise = m_db & ~m_dbp;
      m_ev   = (m_rise != 0) && ($countones(m_db) == 1);
      m_mp   = (m_rise != 0) && !m_ev;
      m_dr   = m_full && !sel_ready && m_ev;
      if (m_ev && (!m_full || sel_ready)) begin
        m_full = 1;
        m_oh   = m_db;
        for (int k = 0; k < NK; k++) if (m_db[k]) m_idx = IW'(k);
      end else if (m_full && sel_ready) begin
        m_full = 0;
      end
      m_dbp = m_db;
      for (int k = 0; k < NK; k++) begin
        hist[k].push_back(m_s2[k]);
        if (hist[k].size() > D) void'(hist[k].pop_front());
        all_diff = (hist[k].size() == D);
        foreach (hist[k][j]) if (hist[k][j] == m_db[k]) all_diff = 0;
        if (all_diff) m_db[k] = m_s2[k];
      end
      m_s2 = m_s1;
      m_s1 = KAL ? ~key : key;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sel_valid",   sel_valid,   m_full);
      chk("any_pressed", any_pressed, |m_db);
      chk("multi_press", multi_press, m_mp);
      chk("dropped",     dropped,     m_dr);
      chk("sel_onehot",  sel_onehot,  m_oh);
      chk("sel_index",   sel_index,   m_idx);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic consume;
    @(negedge clk) sel_ready = 1'b1;
    @(negedge clk) sel_ready = 1'b0;
  endtask

  int  cnt;
  bit  bad;
  int  hold;
  int  pick;

  initial begin
    reset = 1'b1; key = '1; sel_ready = 1'b0;
    @(posedge clk); chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid",  sel_valid, 0);
    chk("reset_onehot", sel_onehot, 0);
    chk("reset_any",    any_pressed, 0);
    chk("reset_pulses", {multi_press, dropped}, 0);
    @(negedge clk) reset = 1'b0;

    // Debounced press of key 1.
    @(negedge clk) key = 4'b1101;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 5) chk("press_any_e5", any_pressed, 0);
      if (k == 6) begin
        chk("press_any_e6",   any_pressed, 1);
        chk("press_valid_e6", sel_valid, 0);
      end
      if (k == 7) begin
        chk("press_valid_e7", sel_valid, 1);
        chk("press_onehot",   sel_onehot, 4'b0010);
        chk("press_index",    sel_index, 1);
      end
    end
    @(negedge clk) key = '1;
    idle(10);
    consume();

    // Bounce shorter than D is ignored.
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk) key = (c < 3) ? 4'b1110 : 4'b1111;
      @(posedge clk); #1;
      if (any_pressed || sel_valid) bad = 1;
    end
    chk("bounce_quiet", bad, 0);

    // Second key while first held.
    @(negedge clk) key = 4'b1101;
    idle(10);
    @(negedge clk) key = 4'b0101;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (multi_press) cnt++;
    end
    chk("multi_count",  cnt, 1);
    chk("multi_onehot", sel_onehot, 4'b0010);
    @(negedge clk) key = '1;
    idle(12);
    consume();

    // Full register drops a later press.
    @(negedge clk) key = 4'b1011;
    cnt = 0;
    for (int c = 0; c < 26; c++) begin
      if (c == 8)  key = 4'b1111;
      if (c == 16) key = 4'b0111;
      @(posedge clk); #1;
      if (dropped) cnt++;
      @(negedge clk);
    end
    chk("drop_count",  cnt, 1);
    chk("drop_onehot", sel_onehot, 4'b0100);
    sel_ready = 1'b1;
    @(posedge clk); #1;
    chk("drop_consumed", sel_valid, 0);
    @(negedge clk) sel_ready = 1'b0; key = '1;
    idle(10);

    // Back-to-back reload while consuming.
    @(negedge clk) key = 4'b1011;
    idle(8);
    @(negedge clk) key = 4'b1111;
    idle(8);
    @(negedge clk) key = 4'b0111;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 6) @(negedge clk) sel_ready = 1'b1;
      if (k == 7) begin
        chk("b2b_valid",   sel_valid, 1);
        chk("b2b_index",   sel_index, 3);
        chk("b2b_dropped", dropped, 0);
      end
    end
    @(negedge clk) sel_ready = 1'b0; key = '1;
    idle(10);
    consume();

    // Reset while full with key 0 held.
    @(negedge clk) key = 4'b1110;
    idle(10);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid",  sel_valid, 0);
    chk("rst_mid_onehot", sel_onehot, 0);
    chk("rst_mid_any",    any_pressed, 0);
    @(negedge clk) reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 6) chk("rst_rel_valid_e6", sel_valid, 0);
      if (k == 7) begin
        chk("rst_rel_valid_e7", sel_valid, 1);
        chk("rst_rel_index",    sel_index, 0);
      end
    end
    @(negedge clk) key = '1;
    idle(10);

    // Randomised phase.
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 99);
      if (pick < 55)      key = ~(NK'(1) << $urandom_range(0, NK-1));
      else if (pick < 75) key = '1;
      else if (pick < 90) key = ~((NK'(1) << $urandom_range(0, NK-1)) | (NK'(1) << $urandom_range(0, NK-1)));
      else                key = NK'($urandom);
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        sel_ready = ($urandom_range(0, 2) == 0);
        reset     = ($urandom_range(0, 399) == 0);
        @(negedge clk);
      end
    end
    reset = 1'b0; sel_ready = 1'b0; key = '1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
